ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, ...) to the keyboard over the same open-collector clock/data pair that the scancode receiver listens on.
- Avalon-MM slave: a data register and a status/control register. Drives the bus only through active-high pull-low enables; the top level builds the tri-state pads.
- The receiver must ignore the line while status.busy=1.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with an Avalon-MM data/status register pair.
// Drives the open-collector clock/data pads only through active-high pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       csi_clk,
    input  logic       csi_reset_n,
    input  logic       avs_s1_address,
    input  logic       avs_s1_read,
    output logic [7:0] avs_s1_readdata,
    input  logic       avs_s1_write,
    input  logic [7:0] avs_s1_writedata,
    output logic       ins_irq0_irq,
    input  logic       coe_kc_in,
    input  logic       coe_kd_in,
    output logic       coe_kc_oe,
    output logic       coe_kd_oe
);

    // state      | meaning
    // IDLE       | lines released, waiting for a data write
    // INHIBIT    | clock held low before the start bit
    // START      | clock and data both low for one cycle
    // SHIFT      | device clocks out data, parity, stop, ack
    // WAIT_IDLE  | waiting for device to release both lines
    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_START, ST_SHIFT, ST_WAIT_IDLE
    } state_t;

    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bitn_q, bitn_d;
    logic [7:0]      tx_q, tx_d;
    logic            par_q, par_d;
    logic            kc_oe_q, kc_oe_d;
    logic            kd_oe_q, kd_oe_d;
    logic            done_q, done_d;
    logic            nack_q, nack_d;
    logic            tout_q, tout_d;
    logic            drop_q, drop_d;
    logic            irq_en_q, irq_en_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      kc_s_q, kd_s_q;
    logic            kc_prev_q;

    logic kc_sync, kd_sync, kfall, busy, wr_data, wr_ctrl;
    logic [7:0] status;

    assign kc_sync = kc_s_q[1];
    assign kd_sync = kd_s_q[1];
    assign kfall   = kc_prev_q & ~kc_sync;
    assign busy    = (state_q != ST_IDLE);
    assign wr_data = avs_s1_write & ~avs_s1_address;
    assign wr_ctrl = avs_s1_write &  avs_s1_address;
    assign status  = {irq_en_q, 2'b00, drop_q, tout_q, nack_q, done_q, busy};

    // Synchronizers reset to the released (high) line level so reset never fakes a kfall.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            kc_s_q    <= 2'b11;
            kd_s_q    <= 2'b11;
            kc_prev_q <= 1'b1;
        end else begin
            kc_s_q    <= {kc_s_q[0], coe_kc_in};
            kd_s_q    <= {kd_s_q[0], coe_kd_in};
            kc_prev_q <= kc_sync;
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitn_q   <= '0;
            tx_q     <= '0;
            par_q    <= 1'b0;
            kc_oe_q  <= 1'b0;
            kd_oe_q  <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            tout_q   <= 1'b0;
            drop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitn_q   <= bitn_d;
            tx_q     <= tx_d;
            par_q    <= par_d;
            kc_oe_q  <= kc_oe_d;
            kd_oe_q  <= kd_oe_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            tout_q   <= tout_d;
            drop_q   <= drop_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitn_d   = bitn_q;
        tx_d     = tx_q;
        par_d    = par_q;
        kc_oe_d  = kc_oe_q;
        kd_oe_d  = kd_oe_q;
        done_d   = done_q;
        nack_d   = nack_q;
        tout_d   = tout_q;
        drop_d   = drop_q;
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;

        if (avs_s1_read)
            rdata_d = avs_s1_address ? status : tx_q;

        // W1C first so that any hardware set below takes priority in the same cycle.
        if (wr_ctrl) begin
            if (avs_s1_writedata[7]) irq_en_d = 1'b1;
            if (avs_s1_writedata[1]) done_d   = 1'b0;
            if (avs_s1_writedata[2]) nack_d   = 1'b0;
            if (avs_s1_writedata[3]) tout_d   = 1'b0;
            if (avs_s1_writedata[4]) drop_d   = 1'b0;
        end

        if (wr_data && busy)
            drop_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    tx_d    = avs_s1_writedata;
                    par_d   = ~^avs_s1_writedata;
                    done_d  = 1'b0;
                    nack_d  = 1'b0;
                    tout_d  = 1'b0;
                    kc_oe_d = 1'b1;
                    cnt_d   = INH_LOAD;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    kd_oe_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_START: begin
                kc_oe_d = 1'b0;
                bitn_d  = '0;
                cnt_d   = TO_LOAD;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (kfall) begin
                    cnt_d  = TO_LOAD;
                    bitn_d = bitn_q + 1'b1;
                    if (bitn_q < 4'd8) begin
                        kd_oe_d = ~tx_q[bitn_q[2:0]];
                    end else if (bitn_q == 4'd8) begin
                        kd_oe_d = ~par_q;
                    end else if (bitn_q == 4'd9) begin
                        kd_oe_d = 1'b0;
                    end else begin
                        nack_d  = kd_sync;
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (cnt_q == '0) begin
                    kc_oe_d = 1'b0;
                    kd_oe_d = 1'b0;
                    tout_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (kc_sync && kd_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    kc_oe_d = 1'b0;
                    kd_oe_d = 1'b0;
                    tout_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign avs_s1_readdata = rdata_q;
    assign ins_irq0_irq    = done_q & irq_en_q;
    assign coe_kc_oe       = kc_oe_q;
    assign coe_kd_oe       = kd_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: register vectors, a frame table and multi-cycle corner sequences
// against a behavioural PS/2 keyboard clocking one edge every 40 system cycles.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       address, read, write;
    logic [7:0] wdata, rdata;
    logic       irq, kc_oe, kd_oe;
    logic       dev_kc_low, dev_kd_low;
    logic       kc_line, kd_line;

    int checks = 0;
    int errors = 0;

    assign kc_line = ~(kc_oe | dev_kc_low);
    assign kd_line = ~(kd_oe | dev_kd_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200)) dut (
        .csi_clk(clk),
        .csi_reset_n(rst_n),
        .avs_s1_address(address),
        .avs_s1_read(read),
        .avs_s1_readdata(rdata),
        .avs_s1_write(write),
        .avs_s1_writedata(wdata),
        .ins_irq0_irq(irq),
        .coe_kc_in(kc_line),
        .coe_kd_in(kd_line),
        .coe_kc_oe(kc_oe),
        .coe_kd_oe(kd_oe)
    );

    typedef struct {
        logic       wr;
        logic       a;
        logic [7:0] d;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] b;
        logic [9:0] bits;
    } frm_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        address = a;
        wdata   = d;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
    endtask

    task automatic bus_rd(input logic a, output logic [7:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = rdata;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!kc_oe && kd_oe) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("start_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_done(output logic [7:0] s);
        s = 8'h00;
        for (int i = 0; i < 60; i++) begin
            bus_rd(1'b1, s);
            if (s[1]) break;
        end
        chk("done_wait", {31'd0, s[1]}, 32'd1);
    endtask

    // Keyboard model: falls the clock, holds 20 cycles, raises it and samples data.
    task automatic device(input int nedges, input bit nack, input bit inject,
                          input bit hold_low, output logic [10:0] smp);
        bit found;
        smp = '0;
        wait_start(found);
        if (!found) return;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= nedges; e++) begin
            dev_kc_low = 1'b1;
            repeat (20) @(negedge clk);
            if (hold_low && e == nedges) return;
            dev_kc_low = 1'b0;
            smp[e-1] = kd_line;
            if (e == 10 && !nack) dev_kd_low = 1'b1;
            if (e == 11) dev_kd_low = 1'b0;
            if (inject && e == 3) begin
                bus_wr(1'b0, 8'hFF);
                repeat (19) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    reg_vec_t    rv [8];
    frm_vec_t    fv [4];
    logic [7:0]  r;
    logic [7:0]  s;
    logic [10:0] smp;
    bit          found;
    int          n;

    initial begin
        rv[0] = '{1'b0, 1'b0, 8'h00, 8'h00};
        rv[1] = '{1'b0, 1'b1, 8'h00, 8'h00};
        rv[2] = '{1'b1, 1'b1, 8'h1E, 8'h00};
        rv[3] = '{1'b0, 1'b1, 8'h00, 8'h00};
        rv[4] = '{1'b1, 1'b1, 8'h80, 8'h00};
        rv[5] = '{1'b0, 1'b1, 8'h00, 8'h80};
        rv[6] = '{1'b1, 1'b1, 8'h00, 8'h00};
        rv[7] = '{1'b0, 1'b1, 8'h00, 8'h80};
        fv[0] = '{8'h00, 10'h300};
        fv[1] = '{8'h01, 10'h201};
        fv[2] = '{8'hF3, 10'h3F3};
        fv[3] = '{8'hFF, 10'h3FF};

        rst_n = 1'b0; address = 1'b0; read = 1'b0; write = 1'b0; wdata = 8'h00;
        dev_kc_low = 1'b0; dev_kd_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", {24'd0, rdata}, 32'h00);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_oe", {30'd0, kc_oe, kd_oe}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (rv[i].wr) bus_wr(rv[i].a, rv[i].d);
            else begin
                bus_rd(rv[i].a, r);
                chk($sformatf("regvec%0d", i), {24'd0, r}, {24'd0, rv[i].exp});
            end
        end
        rst_pulse();

        // Basic frame 0xED with inhibit/start timing and interrupt.
        bus_wr(1'b0, 8'hED);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (kc_oe && !kd_oe) n++;
            else break;
            @(negedge clk);
        end
        chk("inhibit_len", n, 32'd10);
        chk("start_both", {30'd0, kc_oe, kd_oe}, 32'd3);
        @(negedge clk);
        chk("shift_entry", {30'd0, kc_oe, kd_oe}, 32'd1);
        bus_wr(1'b1, 8'h80);
        chk("irq_before_done", {31'd0, irq}, 32'd0);
        device(11, 1'b0, 1'b0, 1'b0, smp);
        chk("bits_ED", {22'd0, smp[9:0]}, 32'h3ED);
        wait_done(s);
        chk("irq_done", {31'd0, irq}, 32'd1);
        chk("status_ED", {24'd0, s}, 32'h82);
        bus_wr(1'b1, 8'h02);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        bus_rd(1'b1, r);
        chk("status_w1c", {24'd0, r}, 32'h80);

        for (int i = 0; i < 4; i++) begin
            bus_wr(1'b0, fv[i].b);
            device(11, 1'b0, 1'b0, 1'b0, smp);
            chk($sformatf("frm%0d_bits", i), {22'd0, smp[9:0]}, {22'd0, fv[i].bits});
            wait_done(s);
            chk($sformatf("frm%0d_status", i), {24'd0, s}, 32'h82);
            bus_rd(1'b0, r);
            chk($sformatf("frm%0d_data", i), {24'd0, r}, {24'd0, fv[i].b});
            bus_wr(1'b1, 8'h02);
        end

        // Write while busy is dropped.
        bus_wr(1'b0, 8'hED);
        device(11, 1'b0, 1'b1, 1'b0, smp);
        chk("busy_bits", {22'd0, smp[9:0]}, 32'h3ED);
        wait_done(s);
        chk("busy_status", {24'd0, s}, 32'h92);
        bus_rd(1'b0, r);
        chk("busy_data", {24'd0, r}, 32'hED);
        bus_wr(1'b1, 8'h12);
        bus_rd(1'b1, r);
        chk("busy_cleared", {24'd0, r}, 32'h80);

        // Asynchronous reset at device edge 5.
        bus_wr(1'b0, 8'hA5);
        device(5, 1'b0, 1'b0, 1'b1, smp);
        chk("pre_reset_kd", {31'd0, kd_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", {30'd0, kc_oe, kd_oe}, 32'd0);
        chk("async_rst_rdata", {24'd0, rdata}, 32'h00);
        dev_kc_low = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(1'b1, r);
        chk("post_rst_status", {24'd0, r}, 32'h00);
        bus_rd(1'b0, r);
        chk("post_rst_data", {24'd0, r}, 32'h00);

        // Nack from device.
        bus_wr(1'b0, 8'h55);
        device(11, 1'b1, 1'b0, 1'b0, smp);
        chk("nack_bits", {22'd0, smp[9:0]}, 32'h355);
        wait_done(s);
        chk("nack_status", {24'd0, s}, 32'h06);
        chk("nack_irq_off", {31'd0, irq}, 32'd0);
        bus_wr(1'b1, 8'h80);
        chk("nack_irq_on", {31'd0, irq}, 32'd1);
        rst_pulse();

        // Timeout: device never clocks.
        bus_wr(1'b0, 8'h5A);
        wait_start(found);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (kd_oe && !kc_oe) n++;
            else break;
        end
        chk("timeout_len", n, 32'd200);
        chk("timeout_oe", {30'd0, kc_oe, kd_oe}, 32'd0);
        bus_rd(1'b1, r);
        chk("timeout_status", {24'd0, r}, 32'h0A);

        // New write accepted after timeout; W1C of done on the cycle done sets.
        bus_wr(1'b0, 8'h3C);
        bus_rd(1'b1, r);
        chk("rewrite_busy", {24'd0, r}, 32'h01);
        bus_rd(1'b0, r);
        chk("rewrite_data", {24'd0, r}, 32'h3C);
        wait_start(found);
        repeat (199) @(negedge clk);
        bus_wr(1'b1, 8'h02);
        chk("collide_oe", {30'd0, kc_oe, kd_oe}, 32'd0);
        bus_rd(1'b1, r);
        chk("collide_status", {24'd0, r}, 32'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
